// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encoding, requester indices and defaults for the UART arbiter
package uart_arb_pkg;
    typedef enum logic [1:0] {IDLE, GRANTED, LAUNCH, BUSY_WAIT} state_t;
    localparam int REQ_INPUT = 0;
    localparam int REQ_GEN = 1;
    localparam int REQ_DISP = 2;
    localparam int REQ_CALC = 3;
    localparam int DEF_IDLE_TIMEOUT = 1_000_000;
endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick of the first eligible bit at or after rr_ptr
module rr_picker #(
    parameter int N = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] rr_ptr,
    output logic [N-1:0]  pick,
    output logic          pick_valid
);
    logic [N-1:0] rot, first;
    // rotate so rr_ptr sits at bit 0, isolate the lowest set bit, rotate back
    always_comb begin
        rot = N'({eligible, eligible} >> rr_ptr);
        first = rot & (-rot);
        pick = N'({first, first} >> (N - int'(rr_ptr)));
        pick_valid = |eligible;
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: grants whole packets round-robin to mode submodules and
// sequences each byte into uart_tx via tx_start/tx_busy.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W = 8,
    parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_en,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic                      pkt_abort
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W = $clog2(IDLE_TIMEOUT + 1);

    state_t state, state_n;
    logic [NUM_REQ-1:0] grant_n, pick;
    logic [PW-1:0] rr_ptr, rr_ptr_n, g_idx, rel_ptr;
    logic [WD_W-1:0] wd, wd_n;
    logic [DATA_W-1:0] tx_data_n, cur_data;
    logic pick_valid, last_q, last_n, ab_q, ab_n, abort_now, tx_start_n, pkt_abort_n;
    logic cur_valid, cur_last, cur_en, wd_hit, hs;

    rr_picker #(.N(NUM_REQ), .PW(PW)) u_pick (
        .eligible(req & req_en),
        .rr_ptr(rr_ptr),
        .pick(pick),
        .pick_valid(pick_valid)
    );

    // owner-side view of the granted requester
    always_comb begin
        cur_data = '0;
        g_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cur_data = cur_data | (req_data[i*DATA_W +: DATA_W] & {DATA_W{grant[i]}});
            if (grant[i]) g_idx = PW'(i);
        end
        cur_valid = |(req_valid & grant);
        cur_last = |(req_last & grant);
        cur_en = |(req_en & grant);
        rel_ptr = (g_idx == PW'(NUM_REQ - 1)) ? '0 : g_idx + PW'(1);
        wd_hit = state == GRANTED && !cur_valid && wd == WD_W'(IDLE_TIMEOUT - 1);
        req_ready = (state == GRANTED && cur_en && !tx_busy) ? grant : '0;
        hs = |(req_valid & req_ready);
    end

    always_comb begin
        state_n = state;
        grant_n = grant;
        rr_ptr_n = rr_ptr;
        wd_n = '0;
        last_n = last_q;
        ab_n = ab_q;
        tx_start_n = 1'b0;
        tx_data_n = tx_data;
        pkt_abort_n = 1'b0;
        abort_now = ab_q | ~cur_en;
        case (state)
            IDLE: begin
                ab_n = 1'b0;
                if (pick_valid) begin
                    grant_n = pick;
                    state_n = GRANTED;
                end
            end
            GRANTED: begin
                if (!cur_en || wd_hit) begin
                    state_n = IDLE;
                    grant_n = '0;
                    rr_ptr_n = rel_ptr;
                    pkt_abort_n = 1'b1;
                end else if (hs) begin
                    tx_data_n = cur_data;
                    last_n = cur_last;
                    tx_start_n = 1'b1;
                    state_n = LAUNCH;
                end else begin
                    wd_n = cur_valid ? wd : wd + WD_W'(1);
                end
            end
            LAUNCH: begin
                ab_n = abort_now;
                state_n = BUSY_WAIT;
            end
            BUSY_WAIT: begin
                ab_n = abort_now;
                if (!tx_busy) begin
                    state_n = (last_q || abort_now) ? IDLE : GRANTED;
                    if (last_q || abort_now) begin
                        grant_n = '0;
                        rr_ptr_n = rel_ptr;
                        pkt_abort_n = abort_now & ~last_q;
                        ab_n = 1'b0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= '0;
            rr_ptr <= '0;
            wd <= '0;
            last_q <= 1'b0;
            ab_q <= 1'b0;
            tx_start <= 1'b0;
            tx_data <= '0;
            pkt_abort <= 1'b0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            rr_ptr <= rr_ptr_n;
            wd <= wd_n;
            last_q <= last_n;
            ab_q <= ab_n;
            tx_start <= tx_start_n;
            tx_data <= tx_data_n;
            pkt_abort <= pkt_abort_n;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenario bench with packet sources and a uart_tx busy model
module tb_uart_tx_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    localparam int TO = 16;
    localparam int FRAME = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] req_en = '0;
    logic [N-1:0] req, req_valid, req_last, req_ready, grant;
    logic [N*W-1:0] req_data;
    logic tx_start, tx_busy, pkt_abort;
    logic [W-1:0] tx_data;

    logic [N-1:0] pend = '0;
    logic [N-1:0] hold = '0;
    int len[N];
    int idx[N];
    logic [W-1:0] bytes[N][8];

    int busy_cnt = 0;
    int ntx = 0;
    int nabort = 0;
    int ng = 0;
    int multi = 0;
    int sbusy = 0;
    logic [W-1:0] txlog[64];
    logic [N-1:0] glog[64];
    logic [N-1:0] gprev = '0;
    int total = 0;
    int passed = 0;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .IDLE_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_en(req_en), .req(req), .req_valid(req_valid),
        .req_data(req_data), .req_last(req_last), .req_ready(req_ready), .grant(grant),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .pkt_abort(pkt_abort)
    );

    always #5 clk = ~clk;
    assign tx_busy = busy_cnt != 0;

    always_comb begin
        req = pend;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = pend[i] & ~hold[i];
            req_data[i*W +: W] = bytes[i][idx[i]];
            req_last[i] = idx[i] == len[i] - 1;
        end
    end

    // uart_tx stand-in plus passive event logs
    always @(posedge clk) begin
        if (tx_start) busy_cnt <= FRAME;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
        if (tx_start) begin
            txlog[ntx] <= tx_data;
            ntx <= ntx + 1;
            if (tx_busy) sbusy <= sbusy + 1;
        end
        if (pkt_abort) nabort <= nabort + 1;
        if (grant != 0 && grant != gprev) begin
            glog[ng] <= grant;
            ng <= ng + 1;
        end
        if ($countones(grant) > 1) multi <= multi + 1;
        gprev <= grant;
    end

    task automatic tick();
        logic [N-1:0] h;
        @(negedge clk);
        h = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (h[i]) begin
                if (idx[i] == len[i] - 1) begin
                    pend[i] = 1'b0;
                    idx[i] = 0;
                end else idx[i]++;
            end
    endtask

    task automatic load(input int r, input int n, input logic [W-1:0] b0, b1, b2, b3, b4);
        len[r] = n;
        idx[r] = 0;
        bytes[r][0] = b0;
        bytes[r][1] = b1;
        bytes[r][2] = b2;
        bytes[r][3] = b3;
        bytes[r][4] = b4;
        pend[r] = 1'b1;
    endtask

    task automatic clear_src();
        pend = '0;
        hold = '0;
        for (int i = 0; i < N; i++) begin
            len[i] = 1;
            idx[i] = 0;
            for (int j = 0; j < 8; j++) bytes[i][j] = '0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_en = '0;
        clear_src();
        repeat (6) tick();
        rst_n = 1'b1;
    endtask

    task automatic run_idle(input string name);
        int k;
        k = 0;
        while (k < 200 && !(grant == 0 && (pend & req_en) == 0)) begin
            tick();
            k++;
        end
        total++;
        if (k >= 200) $display("FAIL %s_timeout: busy after %0d cycles, want under 200", name, k);
        else passed++;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (grant !== '0) $display("FAIL reset_grant: got %b want 0000", grant); else passed++;
        total++; if (req_ready !== '0) $display("FAIL reset_ready: got %b want 0000", req_ready); else passed++;
        total++; if (tx_start !== 1'b0) $display("FAIL reset_tx_start: got %b want 0", tx_start); else passed++;
        total++; if (pkt_abort !== 1'b0) $display("FAIL reset_abort: got %b want 0", pkt_abort); else passed++;
        total++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", tx_data); else passed++;
    endtask

    task automatic test_single();
        int base, ab;
        logic [W-1:0] e[3];
        e = '{8'h41, 8'h42, 8'h0A};
        base = ntx;
        ab = nabort;
        req_en = 4'b0100;
        load(2, 3, 8'h41, 8'h42, 8'h0A, 8'h00, 8'h00);
        tick();
        total++; if (grant !== 4'b0100) $display("FAIL single_grant: got %b want 0100", grant); else passed++;
        total++; if (req_ready !== 4'b0100) $display("FAIL single_ready: got %b want 0100", req_ready); else passed++;
        tick();
        total++; if (tx_start !== 1'b1) $display("FAIL single_tx_start: got %b want 1", tx_start); else passed++;
        total++; if (tx_data !== 8'h41) $display("FAIL single_tx_data: got %h want 41", tx_data); else passed++;
        tick();
        total++; if (tx_start !== 1'b0) $display("FAIL single_start_width: got %b want 0", tx_start); else passed++;
        run_idle("single");
        total++; if (ntx - base !== 3) $display("FAIL single_count: got %0d want 3", ntx - base); else passed++;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (txlog[base+k] !== e[k]) $display("FAIL single_byte%0d: got %h want %h", k, txlog[base+k], e[k]);
            else passed++;
        end
        total++; if (nabort !== ab) $display("FAIL single_no_abort: got %0d want %0d", nabort - ab, 0); else passed++;
        req_en = 4'b1100;
        load(2, 1, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00);
        load(3, 1, 8'h66, 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        total++; if (grant !== 4'b1000) $display("FAIL single_rr_ptr: got %b want 1000", grant); else passed++;
        run_idle("single_ptr");
    endtask

    task automatic test_round_robin();
        int gb;
        logic [N-1:0] e;
        do_reset();
        gb = ng;
        req_en = 4'b1111;
        for (int r = 0; r < N; r++) load(r, 1, 8'(8'hA0 + r), 8'h00, 8'h00, 8'h00, 8'h00);
        run_idle("rr_round1");
        for (int r = 0; r < N; r++) load(r, 1, 8'(8'hB0 + r), 8'h00, 8'h00, 8'h00, 8'h00);
        run_idle("rr_round2");
        total++; if (ng - gb !== 8) $display("FAIL rr_grant_count: got %0d want 8", ng - gb); else passed++;
        for (int k = 0; k < 8; k++) begin
            e = 4'(1 << (k % 4));
            total++;
            if (glog[gb+k] !== e) $display("FAIL rr_order%0d: got %b want %b", k, glog[gb+k], e);
            else passed++;
        end
        total++; if (multi !== 0) $display("FAIL rr_onehot: got %0d multi-bit cycles want 0", multi); else passed++;
    endtask

    task automatic test_gating();
        int gb;
        do_reset();
        gb = ng;
        req_en = 4'b0010;
        load(1, 1, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00);
        load(3, 1, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        total++; if (grant !== 4'b0010) $display("FAIL gate_grant1: got %b want 0010", grant); else passed++;
        run_idle("gate");
        repeat (3) tick();
        total++; if (ng - gb !== 1) $display("FAIL gate_count: got %0d want 1", ng - gb); else passed++;
        total++; if (grant !== 4'b0000) $display("FAIL gate_held_off: got %b want 0000", grant); else passed++;
        req_en = 4'b1010;
        tick();
        total++; if (grant !== 4'b1000) $display("FAIL gate_grant3: got %b want 1000", grant); else passed++;
        run_idle("gate3");
    endtask

    task automatic test_en_drop();
        int base, ab, k;
        do_reset();
        base = ntx;
        ab = nabort;
        req_en = 4'b0001;
        load(0, 5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05);
        k = 0;
        while (ntx - base < 2 && k < 100) begin
            tick();
            k++;
        end
        total++; if (k >= 100) $display("FAIL drop_wait: got %0d launches want 2", ntx - base); else passed++;
        req_en = 4'b0000;
        k = 0;
        while (grant != 0 && k < 50) begin
            tick();
            k++;
        end
        total++; if (pkt_abort !== 1'b1) $display("FAIL drop_abort_at_release: got %b want 1", pkt_abort); else passed++;
        total++; if (grant !== 4'b0000) $display("FAIL drop_grant: got %b want 0000", grant); else passed++;
        repeat (8) tick();
        total++; if (ntx - base !== 2) $display("FAIL drop_launches: got %0d want 2", ntx - base); else passed++;
        total++; if (txlog[base+1] !== 8'h02) $display("FAIL drop_byte2: got %h want 02", txlog[base+1]); else passed++;
        total++; if (nabort - ab !== 1) $display("FAIL drop_abort_count: got %0d want 1", nabort - ab); else passed++;
        total++; if (sbusy !== 0) $display("FAIL start_while_busy: got %0d want 0", sbusy); else passed++;
    endtask

    task automatic test_watchdog();
        int ab;
        do_reset();
        ab = nabort;
        req_en = 4'b0011;
        hold[0] = 1'b1;
        load(0, 1, 8'hEE, 8'h00, 8'h00, 8'h00, 8'h00);
        load(1, 1, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        total++; if (grant !== 4'b0001) $display("FAIL wd_grant: got %b want 0001", grant); else passed++;
        repeat (15) tick();
        total++; if (grant !== 4'b0001) $display("FAIL wd_early: got %b want 0001", grant); else passed++;
        total++; if (pkt_abort !== 1'b0) $display("FAIL wd_early_abort: got %b want 0", pkt_abort); else passed++;
        tick();
        total++; if (grant !== 4'b0000) $display("FAIL wd_release: got %b want 0000", grant); else passed++;
        total++; if (pkt_abort !== 1'b1) $display("FAIL wd_abort: got %b want 1", pkt_abort); else passed++;
        tick();
        total++; if (grant !== 4'b0010) $display("FAIL wd_next_grant: got %b want 0010", grant); else passed++;
        total++; if (nabort - ab !== 1) $display("FAIL wd_abort_count: got %0d want 1", nabort - ab); else passed++;
        pend[0] = 1'b0;
        hold = '0;
        run_idle("wd");
    endtask

    task automatic test_reset_mid();
        int ab;
        do_reset();
        ab = nabort;
        req_en = 4'b0100;
        load(2, 3, 8'hC1, 8'hC2, 8'hC3, 8'h00, 8'h00);
        tick();
        tick();
        total++; if (tx_start !== 1'b1) $display("FAIL mid_launch: got %b want 1", tx_start); else passed++;
        rst_n = 1'b0;
        tick();
        total++; if (grant !== 4'b0000) $display("FAIL mid_grant: got %b want 0000", grant); else passed++;
        total++; if (tx_start !== 1'b0) $display("FAIL mid_tx_start: got %b want 0", tx_start); else passed++;
        total++; if (pkt_abort !== 1'b0) $display("FAIL mid_abort: got %b want 0", pkt_abort); else passed++;
        total++; if (req_ready !== 4'b0000) $display("FAIL mid_ready: got %b want 0000", req_ready); else passed++;
        total++; if (tx_data !== 8'h00) $display("FAIL mid_tx_data: got %h want 00", tx_data); else passed++;
        tick();
        total++; if (nabort !== ab) $display("FAIL mid_abort_count: got %0d want 0", nabort - ab); else passed++;
        do_reset();
    endtask

    initial begin
        clear_src();
        test_reset();
        test_single();
        test_round_robin();
        test_gating();
        test_en_drop();
        test_watchdog();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation ran past 500000 time units");
        $fatal(1);
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter among the mode submodules: data-input echo, generate, display and calculation. Each requester streams a byte packet through a valid/ready handshake. The arbiter grants whole packets round-robin and sequences each byte into `uart_tx` via `tx_start`/`tx_busy`. It sits between the mode submodules and `uart_tx`; the central controller's mode enables gate eligibility.

## Interface
- `NUM_REQ`, 4: number of requesters. Index 0 = input, 1 = generate, 2 = display, 3 = calculation.
- `DATA_W`, 8: byte width.
- `IDLE_TIMEOUT`, 1_000_000: cycles a granted requester may sit without `valid` before its grant is revoked.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_en` in NUM_REQ: mode enables from the central controller; requester i is eligible only while `req_en[i]`=1.
- `req` in NUM_REQ: requester i has a packet pending.
- `req_valid` in NUM_REQ: byte valid, per requester.
- `req_data` in NUM_REQ*DATA_W: packed bytes; requester i occupies `[i*DATA_W +: DATA_W]`.
- `req_last` in NUM_REQ: the current byte is the packet's final byte.
- `req_ready` out NUM_REQ: byte accepted when `valid & ready`.
- `grant` out NUM_REQ: one-hot current owner; all zero when idle.
- `tx_start` out 1: one-cycle start pulse to `uart_tx`.
- `tx_data` out DATA_W: byte to `uart_tx`; stable from `tx_start` until `tx_busy` falls.
- `tx_busy` in 1: from `uart_tx`. Asserted the cycle after it samples `tx_start`; held until the stop bit ends.
- `pkt_abort` out 1: one-cycle pulse when a packet is terminated early.

## Operation
- FSM states: IDLE, GRANTED, LAUNCH, BUSY_WAIT.
- **IDLE**
  - `eligible = req & req_en`.
  - If nonzero, pick the first set bit at or after `rr_ptr`, wrapping modulo NUM_REQ.
  - Register the choice into `grant`; go to GRANTED.
- **GRANTED**
  - `req_ready[g] = !tx_busy`; all other `req_ready` bits are 0.
  - On handshake: `tx_data <= req_data[g]`, `last_q <= req_last[g]`, `tx_start <= 1`; go to LAUNCH.
- **LAUNCH**
  - `tx_start` is high for exactly this cycle; then go to BUSY_WAIT.
  - `tx_busy` is ignored in this cycle.
- **BUSY_WAIT**
  - Wait for `tx_busy` = 0.
  - Then, if `last_q` = 1 or an abort is pending: release the grant, set `rr_ptr <= g+1` (wrapping), go to IDLE.
  - Otherwise go to GRANTED.
- **Abort conditions**
  - `req_en[g]` falls while in GRANTED: release the next cycle, pulse `pkt_abort`, advance `rr_ptr`.
  - `req_en[g]` falls in LAUNCH or BUSY_WAIT: the in-flight byte completes, then release with a `pkt_abort` pulse.
  - Watchdog: a counter runs in GRANTED while `req_valid[g]` = 0 and clears on handshake or state exit. At IDLE_TIMEOUT it triggers release plus `pkt_abort`.
- **Other rules**
  - `req` and `req_en` of non-granted requesters are ignored until IDLE.
  - A requester that drops `req` mid-packet keeps the grant until `last` or abort.
  - Reset values: state IDLE; `grant`, `req_ready`, `tx_start`, `pkt_abort` = 0; `tx_data` = 0; `rr_ptr` = 0; watchdog = 0; `last_q` = 0.
  - Reset mid-packet returns to IDLE immediately with no abort pulse. An in-flight UART byte is owned by `uart_tx`.

## Timing
- `req` seen in IDLE at cycle T → `grant` valid at T+1.
- Earliest handshake is at T+1 → `tx_start` at T+2.
- `tx_busy` rises at T+3; BUSY_WAIT is entered at T+3.
- Per-byte overhead beyond the UART frame: 2 cycles (LAUNCH plus the GRANTED handshake cycle).
- Release to next grant: 1 cycle (IDLE arbitration).
- `tx_start` is never asserted while `tx_busy` = 1.
- At most one `tx_start` per `tx_busy` low→high→low cycle.
- `pkt_abort` is registered and coincides with the cycle the state enters IDLE.

## Structure
- Shared package `uart_arb_pkg`: state encoding, requester index constants (REQ_INPUT=0, REQ_GEN=1, REQ_DISP=2, REQ_CALC=3), default IDLE_TIMEOUT.
- Sub-module `rr_picker`: combinational. Inputs `eligible` and `rr_ptr`; outputs one-hot `pick` and `pick_valid`. Reused by any future shared-resource arbiter.
- The watchdog counter width is `$clog2(IDLE_TIMEOUT+1)`.

## Test plan
- **Single packet:** `req_en`=4'b0100, requester 2 sends 0x41,0x42,0x0A (last on 0x0A). Expect `grant`=4'b0100 at T+1, three `tx_start` pulses carrying those bytes in order, then release and `rr_ptr`=3.
- **Round-robin:** all four requesters enabled and requesting 1-byte packets from reset. Expect grant order 0,1,2,3, then 0 again; `grant` never has more than one bit set.
- **Mode gating:** `req`=4'b1010, `req_en`=4'b0010. Only requester 1 is granted; requester 3 stays un-granted until `req_en[3]` rises.
- **Enable drop mid-byte:** `req_en[g]` falls during BUSY_WAIT of byte 2 of 5. Expect byte 2 to complete, one `pkt_abort` pulse, bytes 3-5 never launched, and `grant`=0.
- **Watchdog:** IDLE_TIMEOUT=16, the granted requester holds `req_valid`=0. Expect release plus `pkt_abort` exactly 16 cycles after entering GRANTED; the next eligible requester is granted 1 cycle later.
- **Reset mid-packet:** assert `rst_n`=0 in LAUNCH. On the next edge expect all outputs at reset values, `tx_start`=0, and no `pkt_abort`.
